// File: rtl/hilo_md_ctrl.sv
// EX-stage HI/LO sequencer: 32-iteration shift-add multiplier and restoring
// divider that stalls the pipeline and emits one HI/LO write on completion.
module hilo_md_ctrl #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stallreq,
  output logic        busy,
  output logic [65:0] ex_hilo_bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [4:0] LAST   = 5'(ITER - 1);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;   // multiplicand, or dividend shifting into quotient
  logic [31:0] opb_q, opb_d;
  logic        sign_a_q, sign_a_d;
  logic        neg_q, neg_d;
  logic [63:0] acc_q, acc_d;
  logic [32:0] rem_q, rem_d;
  logic [63:0] res_q, res_d;   // {hi, lo}

  logic        is_mul, is_div, is_sgn, accept;
  logic [31:0] abs_a, abs_b;
  logic [63:0] acc_nxt;
  logic [32:0] rem_sh, diff, rem_nxt;
  logic [31:0] quo_nxt;
  logic        qbit;

  assign is_mul = (op == 3'd1) || (op == 3'd2);
  assign is_div = (op == 3'd3) || (op == 3'd4);
  assign is_sgn = (op == 3'd1) || (op == 3'd3);
  assign abs_a  = (is_sgn && src_a[31]) ? 32'(0 - src_a) : src_a;
  assign abs_b  = (is_sgn && src_b[31]) ? 32'(0 - src_b) : src_b;
  assign accept = op_valid && !flush && (state_q == S_IDLE) && (is_mul || is_div);

  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sign_a_d = sign_a_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    res_d    = res_q;
    acc_nxt  = 64'd0;
    rem_sh   = 33'd0;
    diff     = 33'd0;
    rem_nxt  = 33'd0;
    quo_nxt  = 32'd0;
    qbit     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          opa_d    = abs_a;
          opb_d    = abs_b;
          sign_a_d = is_sgn && src_a[31];
          neg_d    = is_sgn && (src_a[31] ^ src_b[31]);
          acc_d    = 64'd0;
          rem_d    = 33'd0;
          cnt_d    = 5'd0;
          if (is_mul) begin
            state_d = S_MUL;
          end else if (src_b == 32'd0) begin
            res_d   = {src_a, 32'hFFFF_FFFF};
            state_d = S_DONE;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_nxt = acc_q + (opb_q[cnt_q] ? ({32'd0, opa_q} << cnt_q) : 64'd0);
        acc_d   = acc_nxt;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          res_d   = neg_q ? 64'(0 - acc_nxt) : acc_nxt;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        // Trial subtract; a non-negative difference yields a 1 quotient bit.
        rem_sh  = {rem_q[31:0], opa_q[31]};
        diff    = rem_sh - {1'b0, opb_q};
        qbit    = ~diff[32];
        rem_nxt = qbit ? diff : rem_sh;
        quo_nxt = {opa_q[30:0], qbit};
        rem_d   = rem_nxt;
        opa_d   = quo_nxt;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          res_d   = {sign_a_q ? 32'(0 - rem_nxt[31:0]) : rem_nxt[31:0],
                     neg_q ? 32'(0 - quo_nxt) : quo_nxt};
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      sign_a_q <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= 64'd0;
      rem_q    <= 33'd0;
      res_q    <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sign_a_q <= sign_a_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      res_q    <= res_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign stallreq = !flush && (accept || (state_q == S_MUL) || (state_q == S_DIV));

  always_comb begin
    ex_hilo_bus = 66'd0;
    if (!flush) begin
      if (state_q == S_DONE) begin
        ex_hilo_bus = {2'b11, res_q};
      end else if ((state_q == S_IDLE) && op_valid && (op == 3'd5)) begin
        ex_hilo_bus = {2'b10, src_a, 32'd0};
      end else if ((state_q == S_IDLE) && op_valid && (op == 3'd6)) begin
        ex_hilo_bus = {2'b01, 32'd0, src_a};
      end
    end
  end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Self-checking bench for hilo_md_ctrl: directed corners plus random mul/div
// compared against a plain-arithmetic reference model.
module tb_hilo_md_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq, busy;
  logic [65:0] ex_hilo_bus;

  int n_tests = 0;
  int n_fail  = 0;

  hilo_md_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .op_valid   (op_valid),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .stallreq   (stallreq),
    .busy       (busy),
    .ex_hilo_bus(ex_hilo_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned up;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd1: begin p = 64'(sa * sb); return {2'b11, p}; end
      3'd2: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); return {2'b11, 64'(up)}; end
      3'd3, 3'd4: begin
        if (b == 32'd0) return {2'b11, a, 32'hFFFF_FFFF};
        if (o == 3'd4) return {2'b11, a % b, a / b};
        sq = sa / sb;
        sr = sa % sb;
        return {2'b11, 32'(sr), 32'(sq)};
      end
      default: return 66'd0;
    endcase
  endfunction

  // Settle point for sampling: 1 time unit after the falling edge.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_muldiv(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [65:0] exp;
    int          exp_lat, lat, n_stall;
    exp     = model(o, a, b);
    exp_lat = ((o >= 3'd3) && (b == 32'd0)) ? 1 : 33;
    next_cycle();
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    lat = 0; n_stall = 0;
    while (ex_hilo_bus == 66'd0 && lat < 40) begin
      if (stallreq) n_stall++;
      next_cycle();
      lat++;
    end
    check("latency", 66'(lat), 66'(exp_lat));
    check("stall_cycles", 66'(n_stall), 66'(exp_lat));
    check("done_bus", ex_hilo_bus, exp);
    check("done_stall", {65'd0, stallreq}, 66'd0);
    op_valid = 1'b0;
    next_cycle();
    check("post_busy", {65'd0, busy}, 66'd0);
    check("post_bus", ex_hilo_bus, 66'd0);
  endtask

  task automatic start_and_abort(input bit use_rst, input int at);
    int writes;
    next_cycle();
    op_valid = 1'b1; op = 3'd1; src_a = 32'hFFFF_FFF0; src_b = 32'h0000_1234;
    for (int i = 0; i < at; i++) begin
      next_cycle();
      if (ex_hilo_bus != 66'd0) writes++;
    end
    writes = 0;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    #1;
    if (!use_rst) begin
      check("flush_bus", ex_hilo_bus, 66'd0);
      check("flush_stall", {65'd0, stallreq}, 66'd0);
    end
    next_cycle();
    rst = 1'b0; flush = 1'b0; op_valid = 1'b0;
    #1;
    check("abort_busy", {65'd0, busy}, 66'd0);
    check("abort_stall", {65'd0, stallreq}, 66'd0);
    check("abort_bus", ex_hilo_bus, 66'd0);
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      if (ex_hilo_bus != 66'd0) writes++;
    end
    check("abort_no_write", 66'(writes), 66'd0);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(posedge clk);
    next_cycle();
    rst = 1'b0;
    #1;
    check("rst_busy", {65'd0, busy}, 66'd0);
    check("rst_stall", {65'd0, stallreq}, 66'd0);
    check("rst_bus", ex_hilo_bus, 66'd0);

    do_muldiv(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_muldiv(3'd1, 32'hFFFF_FFFD, 32'd7);
    do_muldiv(3'd3, 32'hFFFF_FFF9, 32'd2);
    do_muldiv(3'd4, 32'd100, 32'd7);
    do_muldiv(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    do_muldiv(3'd4, 32'd5, 32'd0);
    do_muldiv(3'd3, 32'hFFFF_FFF0, 32'd0);

    // MTHI / MTLO are same-cycle writes with no stall.
    next_cycle();
    op_valid = 1'b1; op = 3'd5; src_a = 32'h1234_5678;
    #1;
    check("mthi_bus", ex_hilo_bus, {2'b10, 32'h1234_5678, 32'd0});
    check("mthi_stall", {65'd0, stallreq}, 66'd0);
    next_cycle();
    op = 3'd6; src_a = 32'h0000_ABCD;
    #1;
    check("mtlo_bus", ex_hilo_bus, {2'b01, 32'd0, 32'h0000_ABCD});
    check("mtlo_busy", {65'd0, busy}, 66'd0);
    next_cycle();
    op = 3'd7;
    #1;
    check("op7_bus", ex_hilo_bus, 66'd0);
    op = 3'd0;
    #1;
    check("op0_stall", {65'd0, stallreq}, 66'd0);

    // Flush in IDLE beats acceptance.
    next_cycle();
    op = 3'd2; flush = 1'b1;
    #1;
    check("idle_flush_stall", {65'd0, stallreq}, 66'd0);
    next_cycle();
    flush = 1'b0; op_valid = 1'b0;
    #1;
    check("idle_flush_busy", {65'd0, busy}, 66'd0);

    start_and_abort(1'b0, 10);
    start_and_abort(1'b1, 20);
    do_muldiv(3'd4, 32'hDEAD_BEEF, 32'h0000_0123);

    for (int i = 0; i < 24; i++) begin
      r_op = 3'($urandom_range(1, 4));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: r_b = 32'($urandom_range(1, 15));
        2: r_a = 32'h8000_0000;
        3: r_b = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_muldiv(r_op, r_a, r_b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_md_ctrl.md
Name: hilo_md_ctrl

Overview:
- Multi-cycle multiply/divide sequencer in the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decoder.
- Runs a 32-iteration shift-add multiplier or restoring divider and holds the pipeline via stallreq.
- Drives the 66-bit EX-stage HI/LO write bus {hi_we, lo_we, hi[31:0], lo[31:0]}, which the HI/LO register file consumes for forwarding and write-back.
- One operation in flight at a time.

Parameters:
- ITER, 32, iteration count for both mul and div; fixed at 32 for 32-bit operands.

Ports:
- clk  input  1  clock, all state on posedge
- rst  input  1  synchronous, active-high reset
- flush  input  1  cancel in-flight operation (exception/branch flush); no HI/LO write
- op_valid  input  1  EX stage presents a HI/LO-writing instruction
- op  input  3  1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; 0/7 ignored
- src_a  input  32  rs value (multiplicand/dividend/MTHI-MTLO data)
- src_b  input  32  rt value (multiplier/divisor)
- stallreq  output  1  request to freeze PC..EX while unit busy
- busy  output  1  state != IDLE
- ex_hilo_bus  output  66  {hi_we, lo_we, hi_in, lo_in}

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, all datapath regs 0. Combinational outputs then evaluate to stallreq=0, busy=0, ex_hilo_bus=66'b0. Reset mid-operation aborts the operation; no write is ever emitted for it.
- States: IDLE, MUL, DIV, DONE.
- IDLE, op_valid with op=1/2: latch |src_a|, |src_b| (signed ops) or raw (unsigned), plus sign flags. Clear the 64-bit accumulator, cnt=0, go to MUL.
- IDLE, op_valid with op=3/4, src_b!=0: latch operands the same way, go to DIV.
- IDLE, op_valid with op=3/4, src_b==0: go directly to DONE. Result is hi=src_a, lo=32'hFFFF_FFFF for both signed and unsigned.
- MUL: each cycle add the shifted multiplicand if multiplier bit[cnt] is 1, cnt++. After cnt reaches ITER-1, go to DONE. For MULT, negate the 64-bit product if sign_a^sign_b.
- DIV: restoring, one quotient bit per cycle, MSB first. After ITER cycles, go to DONE.
- DIV signed fixup: quotient is negated if sign_a^sign_b; remainder takes the sign of the dividend. 0x80000000 / -1 gives lo=0x80000000, hi=0.
- DONE: ex_hilo_bus={1,1,hi,lo} for exactly this one cycle, stallreq=0. Next state is IDLE unconditionally.
- The op_valid still presented in the DONE cycle (the same held instruction) must not restart the unit.
- stallreq timing: combinational. It is 1 in the IDLE acceptance cycle (op 1–4 with op_valid, excluding the div-by-zero shortcut, where it is also 1) and in every MUL/DIV cycle. It is 0 in DONE and IDLE otherwise.
- Latency: a mul/div accepted at cycle T gives DONE at T+33 (T+1 for div-by-zero); stallreq is high over T..T+32.
- MTHI (op=5) in IDLE: ex_hilo_bus={1,0,src_a,32'b0} in the same cycle, combinational, no stall, no state change. MTLO (op=6): {0,1,32'b0,src_a}.
- MTHI/MTLO while busy cannot occur because the pipeline is stalled. If it appears, ignore it.
- flush: any state goes to IDLE next cycle. In the flush cycle, ex_hilo_bus=0 and stallreq=0. Flush has priority over acceptance and DONE output. rst has priority over flush.
- Outside DONE and MTHI/MTLO cycles, ex_hilo_bus=66'b0.
- Arithmetic: the accumulator is 64 bits and the divider remainder register is 33 bits. Negation is two's complement modulo 2^64 or 2^32.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → stallreq high 33 cycles, then one-cycle bus {1,1,0xFFFFFFFE,0x00000001}.
- MULT −3 × 7 (0xFFFFFFFD, 7) → DONE at T+33 with hi=0xFFFFFFFF, lo=0xFFFFFFEB; op_valid held during DONE causes no restart; busy=0 at T+34.
- DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5/0 → DONE at T+1, bus {1,1,0x00000005,0xFFFFFFFF}, stallreq high only in cycle T.
- MTHI 0x12345678 in IDLE → same-cycle bus {1,0,0x12345678,0}, stallreq=0; MTLO 0xABCD → {0,1,0,0xABCD}.
- Start MULT, assert flush at T+10 → IDLE at T+11, no write ever emitted. Repeat with rst at T+20 → all outputs 0 next cycle, a new DIVU is accepted normally.
